// File: rtl/mem2io_bank.sv
// Memory-mapped IO bank: routes CPU accesses to SRAM, NUM_IO output registers or a switch readback port.
// Optional MEM2IO_BYTE_LANE_EN: IO writes honour the captured UB/LB byte-lane enables.
module mem2io_bank #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 20,
  parameter int NUM_IO   = 4,
  parameter int WAIT_CYC = 2
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Req,
  input  logic [ADDR_W-1:0]        ADDR,
  input  logic                     CE,
  input  logic                     UB,
  input  logic                     LB,
  input  logic                     OE,
  input  logic                     WE,
  input  logic [DATA_W-1:0]        Switches,
  input  logic [DATA_W-1:0]        Data_from_CPU,
  input  logic [DATA_W-1:0]        Data_from_SRAM,
  output logic [DATA_W-1:0]        Data_to_CPU,
  output logic [DATA_W-1:0]        Data_to_SRAM,
  output logic                     SRAM_OE_N,
  output logic                     SRAM_WE_N,
  output logic                     Ready,
  output logic                     Busy,
  output logic [NUM_IO*DATA_W-1:0] IO_out
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LATCH  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [ADDR_W-1:0] ADDR_TOP = '1;
  localparam logic [3:0]        WAIT_LD  = 4'(WAIT_CYC);

  logic [1:0]               state;
  logic [3:0]               cnt;
  logic [ADDR_W-1:0]        addr_q;
  logic                     ub_q, lb_q, oe_q, we_q;
  logic [DATA_W-1:0]        wdata_q;
  logic [DATA_W-1:0]        rdata_q;
  logic [NUM_IO*DATA_W-1:0] io_q;

  logic [NUM_IO-1:0]        io_hit;
  logic                     sw_hit, sram_sel;
  logic                     is_rd, is_wr, done_entry;
  logic [DATA_W-1:0]        io_rd, rd_src, wmask;

  // Decode works on the captured address so live ADDR changes cannot disturb an access.
  always_comb begin
    io_hit = '0;
    io_rd  = '0;
    for (int unsigned k = 0; k < NUM_IO; k++) begin
      io_hit[k] = (addr_q == ADDR_TOP - ADDR_W'(k));
      if (io_hit[k]) io_rd = io_q[k*DATA_W +: DATA_W];
    end
    sw_hit   = (addr_q == ADDR_TOP - ADDR_W'(NUM_IO));
    sram_sel = ~(|io_hit) & ~sw_hit;
    is_rd    = we_q & ~oe_q;
    is_wr    = ~we_q;
    rd_src   = sram_sel ? Data_from_SRAM : (sw_hit ? Switches : io_rd);
    done_entry = ((state == S_LATCH) && !sram_sel) ||
                 ((state == S_ACCESS) && (cnt == 4'd1));
  end

`ifdef MEM2IO_BYTE_LANE_EN
  always_comb begin
    wmask = '0;
    for (int unsigned b = 0; b < DATA_W/8; b++)
      wmask[b*8 +: 8] = {8{((b % 2) == 0) ? ~lb_q : ~ub_q}};
  end
`else
  logic unused_lanes;
  assign unused_lanes = &{1'b0, ub_q, lb_q};
  assign wmask = '1;
`endif

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      ub_q    <= 1'b1;
      lb_q    <= 1'b1;
      oe_q    <= 1'b1;
      we_q    <= 1'b1;
      wdata_q <= '0;
      rdata_q <= '0;
      io_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Req && !CE) begin
            addr_q  <= ADDR;
            ub_q    <= UB;
            lb_q    <= LB;
            oe_q    <= OE;
            we_q    <= WE;
            wdata_q <= Data_from_CPU;
            state   <= S_LATCH;
          end
        end
        S_LATCH: begin
          if (sram_sel) begin
            cnt   <= WAIT_LD;
            state <= S_ACCESS;
          end else begin
            state <= S_DONE;
          end
        end
        S_ACCESS: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase

      if (done_entry) begin
        rdata_q <= is_rd ? rd_src : '0;
        if (is_wr) begin
          for (int unsigned k = 0; k < NUM_IO; k++)
            if (io_hit[k])
              io_q[k*DATA_W +: DATA_W] <= (io_q[k*DATA_W +: DATA_W] & ~wmask) | (wdata_q & wmask);
        end
      end
    end
  end

  assign Data_to_CPU  = rdata_q;
  assign Data_to_SRAM = wdata_q;
  assign IO_out       = io_q;
  assign Ready        = (state == S_DONE);
  assign Busy         = (state != S_IDLE);
  assign SRAM_OE_N    = ~((state == S_ACCESS) && is_rd);
  assign SRAM_WE_N    = ~((state == S_ACCESS) && is_wr);

endmodule

// File: tb/tb_mem2io_bank.sv
// Randomized and directed bench for mem2io_bank against a transaction-level reference model.
module tb_mem2io_bank;
  localparam int DW  = 16;
  localparam int AW  = 20;
  localparam int NIO = 4;
  localparam int WC  = 2;
  localparam int unsigned TOP = (2**AW) - 1;

  logic            Clk = 1'b0;
  logic            Reset = 1'b0;
  logic            Req = 1'b0;
  logic [AW-1:0]   ADDR = '0;
  logic            CE = 1'b1, UB = 1'b1, LB = 1'b1, OE = 1'b1, WE = 1'b1;
  logic [DW-1:0]   Switches = '0, Data_from_CPU = '0, Data_from_SRAM = '0;
  logic [DW-1:0]   Data_to_CPU, Data_to_SRAM;
  logic            SRAM_OE_N, SRAM_WE_N, Ready, Busy;
  logic [NIO*DW-1:0] IO_out;

  mem2io_bank #(.DATA_W(DW), .ADDR_W(AW), .NUM_IO(NIO), .WAIT_CYC(WC)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .ADDR(ADDR), .CE(CE), .UB(UB), .LB(LB),
    .OE(OE), .WE(WE), .Switches(Switches), .Data_from_CPU(Data_from_CPU),
    .Data_from_SRAM(Data_from_SRAM), .Data_to_CPU(Data_to_CPU), .Data_to_SRAM(Data_to_SRAM),
    .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N), .Ready(Ready), .Busy(Busy), .IO_out(IO_out)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [DW-1:0] m_io [NIO];
  int            e_lat, e_oe, e_we;
  logic [DW-1:0] e_rd;

  // Observations from one access
  int            ob_ready, ob_ready_at, ob_oe, ob_we, ob_busy, ob_d2s_bad;
  logic [DW-1:0] ob_rdata, ob_hold;
  logic [3:0]    ob_rst;

  function automatic logic [NIO*DW-1:0] m_pack();
    logic [NIO*DW-1:0] v;
    for (int k = 0; k < NIO; k++) v[k*DW +: DW] = m_io[k];
    return v;
  endfunction

  task automatic m_clear();
    for (int k = 0; k < NIO; k++) m_io[k] = '0;
  endtask

  // Transaction-level model: classify address, derive latency, strobe cycles and read data.
  task automatic model_access(input logic [AW-1:0] a, input logic we, input logic oe,
                              input logic ub, input logic lb, input logic [DW-1:0] wd,
                              input logic [DW-1:0] sram, input logic [DW-1:0] sw);
    int unsigned d;
    logic rd;
    logic [DW-1:0] nv;
    d  = TOP - int'(a);
    rd = we && !oe;
    e_oe = 0; e_we = 0; e_rd = '0;
    if (d < NIO) begin
      e_lat = 2;
      if (rd) e_rd = m_io[d];
      if (!we) begin
        nv = m_io[d];
        for (int b = 0; b < DW/8; b++) begin
`ifdef MEM2IO_BYTE_LANE_EN
          if (((b % 2 == 0) && !lb) || ((b % 2 == 1) && !ub)) nv[b*8 +: 8] = wd[b*8 +: 8];
`else
          nv[b*8 +: 8] = wd[b*8 +: 8];
`endif
        end
        m_io[d] = nv;
      end
    end else if (d == NIO) begin
      e_lat = 2;
      if (rd) e_rd = sw;
    end else begin
      e_lat = WC + 2;
      if (rd) begin e_oe = WC; e_rd = sram; end
      if (!we) e_we = WC;
    end
  endtask

  // Drives one request, then scrambles the live inputs and records what the DUT does.
  task automatic run_access(input logic [AW-1:0] a, input logic we, input logic oe,
                            input logic ub, input logic lb, input logic [DW-1:0] wd,
                            input bit pulse, input int rst_at);
    @(negedge Clk);
    ADDR = a; WE = we; OE = oe; UB = ub; LB = lb; CE = 1'b0; Data_from_CPU = wd; Req = 1'b1;
    ob_ready = 0; ob_ready_at = -1; ob_oe = 0; ob_we = 0; ob_busy = 0; ob_d2s_bad = 0;
    ob_rdata = '0; ob_rst = '0;
    for (int n = 1; n <= WC + 6; n++) begin
      @(negedge Clk);
      if (n == 1) begin
        Req = 1'b0;
        Data_from_CPU = DW'($urandom);
        ADDR = AW'($urandom);
        {WE, OE, UB, LB} = 4'($urandom);
      end
      if (pulse && n == 2) Req = 1'b1;
      if (pulse && n == 3) Req = 1'b0;
      if (n == rst_at) begin
        Reset = 1'b0;
        #1 ob_rst = {SRAM_OE_N, SRAM_WE_N, Busy, Ready};
      end
      if (rst_at > 0 && n == rst_at + 2) Reset = 1'b1;
      if (Ready) begin ob_ready++; ob_ready_at = n; ob_rdata = Data_to_CPU; end
      if (!SRAM_OE_N) ob_oe++;
      if (!SRAM_WE_N) begin
        ob_we++;
        if (Data_to_SRAM !== wd) ob_d2s_bad++;
      end
      if (Busy) ob_busy++;
    end
    ob_hold = Data_to_CPU;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    #1;
    n_cmp++;
    if ({Ready, Busy, SRAM_OE_N, SRAM_WE_N} !== 4'b0011) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 0011", {Ready, Busy, SRAM_OE_N, SRAM_WE_N});
    end
    n_cmp++;
    if (Data_to_CPU !== '0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", Data_to_CPU); end
    n_cmp++;
    if (IO_out !== '0) begin n_err++; $display("FAIL reset_io: got %h want 0", IO_out); end
    m_clear();
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
  endtask

  task automatic test_io_write();
    model_access(20'hFFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 16'hBEEF, '0, '0);
    run_access(20'hFFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 16'hBEEF, 1'b0, 0);
    n_cmp++;
    if (ob_ready != 1 || ob_ready_at != 2) begin
      n_err++; $display("FAIL io_write_lat: got cnt %0d at %0d want 1 at 2", ob_ready, ob_ready_at);
    end
    n_cmp++;
    if (IO_out[15:0] !== 16'hBEEF) begin n_err++; $display("FAIL io_write_val: got %h want beef", IO_out[15:0]); end
    n_cmp++;
    if (ob_oe != 0 || ob_we != 0) begin n_err++; $display("FAIL io_write_strobe: got oe %0d we %0d want 0 0", ob_oe, ob_we); end
  endtask

  task automatic test_sram_read();
    Data_from_SRAM = 16'h1234;
    model_access(20'h00010, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h1234, Switches);
    run_access(20'h00010, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 0);
    n_cmp++;
    if (ob_oe != 2 || ob_we != 0) begin n_err++; $display("FAIL sram_rd_strobe: got oe %0d we %0d want 2 0", ob_oe, ob_we); end
    n_cmp++;
    if (ob_ready != 1 || ob_ready_at != 4) begin
      n_err++; $display("FAIL sram_rd_lat: got cnt %0d at %0d want 1 at 4", ob_ready, ob_ready_at);
    end
    n_cmp++;
    if (ob_rdata !== 16'h1234) begin n_err++; $display("FAIL sram_rd_data: got %h want 1234", ob_rdata); end
  endtask

  task automatic test_switch_read();
    Switches = 16'h00A5;
    model_access(20'hFFFFB, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, Data_from_SRAM, 16'h00A5);
    run_access(20'hFFFFB, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 0);
    n_cmp++;
    if (ob_rdata !== 16'h00A5 || ob_ready_at != 2) begin
      n_err++; $display("FAIL switch_rd: got %h at %0d want 00a5 at 2", ob_rdata, ob_ready_at);
    end
  endtask

  task automatic test_byte_lane();
    logic [DW-1:0] want;
    model_access(20'hFFFFE, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1111, '0, '0);
    run_access(20'hFFFFE, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1111, 1'b0, 0);
    model_access(20'hFFFFE, 1'b0, 1'b1, 1'b0, 1'b1, 16'hABCD, '0, '0);
    run_access(20'hFFFFE, 1'b0, 1'b1, 1'b0, 1'b1, 16'hABCD, 1'b0, 0);
`ifdef MEM2IO_BYTE_LANE_EN
    want = 16'hAB11;
`else
    want = 16'hABCD;
`endif
    n_cmp++;
    if (IO_out[31:16] !== want) begin n_err++; $display("FAIL byte_lane: got %h want %h", IO_out[31:16], want); end
    n_cmp++;
    if (IO_out !== m_pack()) begin n_err++; $display("FAIL byte_lane_all: got %h want %h", IO_out, m_pack()); end
  endtask

  task automatic test_busy_req();
    model_access(20'h00123, 1'b0, 1'b1, 1'b0, 1'b0, 16'h5A5A, '0, '0);
    run_access(20'h00123, 1'b0, 1'b1, 1'b0, 1'b0, 16'h5A5A, 1'b1, 0);
    n_cmp++;
    if (ob_ready != 1) begin n_err++; $display("FAIL busy_req_ready: got %0d pulses want 1", ob_ready); end
    n_cmp++;
    if (ob_we != WC || ob_oe != 0) begin n_err++; $display("FAIL busy_req_we: got we %0d oe %0d want %0d 0", ob_we, ob_oe, WC); end
    n_cmp++;
    if (ob_d2s_bad != 0) begin n_err++; $display("FAIL busy_req_wdata: got %0d bad cycles want 0", ob_d2s_bad); end
    n_cmp++;
    if (ob_busy != WC + 2) begin n_err++; $display("FAIL busy_req_busy: got %0d want %0d", ob_busy, WC + 2); end
  endtask

  task automatic test_reset_mid();
    run_access(20'h00200, 1'b0, 1'b1, 1'b0, 1'b0, 16'h7777, 1'b0, 2);
    m_clear();
    n_cmp++;
    if (ob_rst !== 4'b1100) begin n_err++; $display("FAIL rst_mid_ctrl: got %b want 1100", ob_rst); end
    n_cmp++;
    if (ob_ready != 0) begin n_err++; $display("FAIL rst_mid_ready: got %0d want 0", ob_ready); end
    n_cmp++;
    if (IO_out !== '0) begin n_err++; $display("FAIL rst_mid_io: got %h want 0", IO_out); end
    run_access(20'hFFFFD, 1'b0, 1'b1, 1'b0, 1'b0, 16'h4321, 1'b0, 1);
    n_cmp++;
    if (ob_ready != 0 || IO_out !== '0) begin
      n_err++; $display("FAIL rst_latch_abort: got ready %0d io %h want 0 0", ob_ready, IO_out);
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    logic we, oe, ub, lb;
    logic [DW-1:0] wd;
    bit pulse;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 2))
        0: a = AW'(TOP - $urandom_range(0, NIO));
        1: a = AW'($urandom);
        default: a = AW'($urandom_range(0, 255));
      endcase
      we = 1'($urandom); oe = we ? 1'b0 : 1'($urandom);
      ub = 1'($urandom); lb = 1'($urandom);
      wd = DW'($urandom); pulse = 1'($urandom);
      Data_from_SRAM = DW'($urandom);
      Switches = DW'($urandom);
      model_access(a, we, oe, ub, lb, wd, Data_from_SRAM, Switches);
      run_access(a, we, oe, ub, lb, wd, pulse, 0);
      n_cmp++;
      if (ob_ready != 1 || ob_ready_at != e_lat || ob_busy != e_lat) begin
        n_err++;
        $display("FAIL rnd_timing[%0d] a=%h: got ready %0d at %0d busy %0d want 1 at %0d", i, a, ob_ready, ob_ready_at, ob_busy, e_lat);
      end
      n_cmp++;
      if (ob_oe != e_oe || ob_we != e_we || ob_d2s_bad != 0) begin
        n_err++;
        $display("FAIL rnd_strobe[%0d] a=%h: got oe %0d we %0d bad %0d want %0d %0d 0", i, a, ob_oe, ob_we, ob_d2s_bad, e_oe, e_we);
      end
      n_cmp++;
      if (ob_rdata !== e_rd || ob_hold !== e_rd) begin
        n_err++; $display("FAIL rnd_rdata[%0d] a=%h: got %h hold %h want %h", i, a, ob_rdata, ob_hold, e_rd);
      end
      n_cmp++;
      if (IO_out !== m_pack()) begin
        n_err++; $display("FAIL rnd_io[%0d] a=%h: got %h want %h", i, a, IO_out, m_pack());
      end
    end
  endtask

  initial begin
    test_reset();
    test_io_write();
    test_sram_read();
    test_switch_read();
    test_byte_lane();
    test_busy_req();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
